// File: rtl/fir_sym_serial.sv
// Folded-symmetric FIR with one serial MAC and NBANKS run-time writable half-length coefficient banks.
// Define FIR_SAT_EN to clamp the rounded result to the output range; otherwise the result wraps.
module fir_sym_serial #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned TAPS      = 64,
  parameter int unsigned NBANKS    = 2,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned OUT_SHIFT = 15,
  localparam int unsigned BANK_W   = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int unsigned HALF     = TAPS / 2,
  localparam int unsigned K_W      = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic              coef_we,
  input  logic [BANK_W-1:0] coef_bank,
  input  logic [K_W-1:0]    coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned X_W    = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + 1 + COEF_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(HALF - 1);
  localparam logic signed [ACC_W-1:0] RND =
    (OUT_SHIFT == 0) ? '0 : (ACC_W'(1) << (OUT_SHIFT - 1));
`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t                   state, state_n;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] coef [NBANKS][HALF];
  logic [BANK_W-1:0]        cur_bank;
  logic [K_W-1:0]           k;
  logic signed [ACC_W-1:0]  acc;

  logic [X_W-1:0]           idx_lo, idx_hi;
  logic                     rd_ok, wr_bank_ok, wr_ok;
  logic signed [DATA_W:0]   pre;
  logic signed [COEF_W-1:0] c_rd;
  logic signed [PROD_W-1:0] pre_x, c_x, prod;
  logic signed [ACC_W-1:0]  rsum;
  logic [DATA_W-1:0]        r_out;
`ifdef FIR_SAT_EN
  logic signed [ACC_W-1:0]  r;
`endif

  // Bank indices past NBANKS exist only when NBANKS is not a power of two.
  if ((1 << BANK_W) == NBANKS) begin : g_bank_full
    assign rd_ok      = 1'b1;
    assign wr_bank_ok = 1'b1;
  end else begin : g_bank_part
    assign rd_ok      = 32'(cur_bank) < NBANKS;
    assign wr_bank_ok = 32'(coef_bank) < NBANKS;
  end

  assign in_ready = ~busy;
  assign wr_ok    = coef_we && wr_bank_ok && !(busy && (coef_bank == cur_bank));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (in_valid) state_n = S_MAC;
      S_MAC:   if (k == K_LAST) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_n != S_IDLE);
  end

  // Pre-add of the mirrored tap pair, then one product per MAC cycle.
  always_comb begin
    idx_lo = X_W'(k);
    idx_hi = X_W'(TAPS - 1) - idx_lo;
    pre    = {x[idx_lo][DATA_W-1], x[idx_lo]} + {x[idx_hi][DATA_W-1], x[idx_hi]};
    c_rd   = rd_ok ? coef[cur_bank][k] : '0;
    pre_x  = {{COEF_W{pre[DATA_W]}}, pre};
    c_x    = {{(DATA_W+1){c_rd[COEF_W-1]}}, c_rd};
    prod   = pre_x * c_x;
  end

  always_comb begin
    rsum = acc + RND;
`ifdef FIR_SAT_EN
    r = rsum >>> OUT_SHIFT;
    if (r > SMAX)      r_out = SMAX[DATA_W-1:0];
    else if (r < SMIN) r_out = SMIN[DATA_W-1:0];
    else               r_out = r[DATA_W-1:0];
`else
    r_out = DATA_W'(rsum >>> OUT_SHIFT);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      cur_bank  <= '0;
      k         <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          x[0] <= in_data;
          for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
          cur_bank <= bank_sel;
          acc      <= '0;
          k        <= '0;
        end
        S_MAC: begin
          acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
          k   <= k + K_W'(1);
        end
        S_DONE: begin
          out_data  <= r_out;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The bank in use is write-protected until the result is out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBANKS; b++)
        for (int i = 0; i < HALF; i++) coef[b][i] <= '0;
    end else if (wr_ok) begin
      coef[coef_bank][coef_addr] <= coef_wdata;
    end
  end

endmodule
